// File: rtl/shift_add_mult16.sv
// ---------------------------------------------------------------------------
// shift_add_mult16
//
// Sequential WIDTH x WIDTH unsigned shift-and-add multiplier controller.
// This block owns the multiplicand register (m_reg), the partial-product
// register pair (p_hi/p_lo) and the iteration counter. It does not contain an
// adder. Instead it drives an external combinational ripple-carry adder and
// consumes that adder's sum in the same clock cycle, doing one add per clock
// for WIDTH iterations.
//
// Algorithm: the product register starts as {0, multiplier}. Each iteration
// adds the multiplicand into the upper half when the lowest product bit is
// set. It then shifts the 2*WIDTH+1 bit value {carry, sum, p_lo} right by
// one. After WIDTH iterations the multiplier bits have all been shifted out
// and {p_hi, p_lo} holds the full product.
//
// Parameters
//   WIDTH     operand width; must match the external adder width (16)
//   CNT_W     iteration counter width (holds 0..WIDTH)
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   synchronous active-high reset
//   start     in   request; only sampled while idle
//   op_a      in   multiplicand, captured on an accepted start
//   op_b      in   multiplier, captured on an accepted start
//   busy      out  high while iterating
//   done      out  one-cycle pulse once the product is final
//   product   out  {p_hi, p_lo}; valid from done until the next accepted start
//   add_a     out  adder operand a: current p_hi
//   add_b     out  adder operand b: multiplicand when p_lo[0] is set, else 0
//   add_cin   out  adder carry-in, always 0
//   add_s     in   adder sum (combinational, same cycle)
//   add_cout  in   adder carry-out
//
// Build option
//   MULT_ZERO_SKIP_EN  when defined, an accepted start with a zero operand
//                      goes straight to the done state with a zero product
//                      and never enters the iteration phase.
// ---------------------------------------------------------------------------
module shift_add_mult16 #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic               add_cin,
  input  logic [WIDTH-1:0]   add_s,
  input  logic               add_cout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The counter value seen during the last iteration. At that edge the
  // machine moves on to the done state.
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   m_reg;
  logic [WIDTH-1:0]   m_nxt;
  logic [WIDTH-1:0]   p_hi;
  logic [WIDTH-1:0]   p_hi_nxt;
  logic [WIDTH-1:0]   p_lo;
  logic [WIDTH-1:0]   p_lo_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;

  // State and datapath registers. Reset clears everything, including the
  // partial product, so an aborted multiply leaves no trace and no done
  // pulse follows it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      m_reg <= '0;
      p_hi  <= '0;
      p_lo  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      m_reg <= m_nxt;
      p_hi  <= p_hi_nxt;
      p_lo  <= p_lo_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and next-datapath logic. By default everything holds, so the
  // product stays visible while idle until a new start is accepted.
  // A start request is ignored outside IDLE: there is no restart and no
  // queueing.
  //
  // In RUN, the external adder has already formed p_hi + (m or 0) this
  // cycle. Its 17-bit result, followed by the upper bits of p_lo, makes the
  // shifted product. The carry therefore lands in p_hi's top bit and is
  // never lost.
  always_comb begin
    state_nxt = state;
    m_nxt     = m_reg;
    p_hi_nxt  = p_hi;
    p_lo_nxt  = p_lo;
    cnt_nxt   = cnt;

    unique case (state)
      IDLE: begin
        if (start) begin
          m_nxt     = op_a;
          p_hi_nxt  = '0;
          p_lo_nxt  = op_b;
          cnt_nxt   = '0;
          state_nxt = RUN;
`ifdef MULT_ZERO_SKIP_EN
          if ((op_a == '0) || (op_b == '0)) begin
            m_nxt     = '0;
            p_lo_nxt  = '0;
            state_nxt = DONE;
          end
`endif
        end
      end

      RUN: begin
        {p_hi_nxt, p_lo_nxt} = {add_cout, add_s, p_lo[WIDTH-1:1]};
        cnt_nxt              = cnt + 1'b1;
        if (cnt == LAST_ITER) begin
          state_nxt = DONE;
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs are decoded from registers only. There is deliberately no path
  // from add_s/add_cout back to add_a/add_b/add_cin, so there is no
  // combinational loop through the external adder. Outside RUN the adder
  // operands keep tracking the registers. That is harmless because the sum
  // is only consumed while iterating.
  always_comb begin
    busy    = (state == RUN);
    done    = (state == DONE);
    product = {p_hi, p_lo};
    add_a   = p_hi;
    add_b   = p_lo[0] ? m_reg : '0;
    add_cin = 1'b0;
  end

endmodule
